// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared function codes and flag bit positions for alu_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [2:0] {
        RA   = 3'b000,
        RB   = 3'b001,
        RADD = 3'b010,
        RSUB = 3'b011,
        RAND = 3'b100,
        ROR  = 3'b101,
        RXOR = 3'b110,
        RNOT = 3'b111
    } alu_func_e;

    localparam int FLAG_V = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_addsub.sv
// ============================================================================
// Module      : alu_addsub
// Description : Combinational N-bit adder/subtractor with carry/borrow and
//               signed-overflow outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_addsub #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_sub,
    output logic [N-1:0] o_sum,
    output logic         o_carry,
    output logic         o_ovf
);

    logic [N:0] w_ext;

    // Zero-extended operation: bit N is the carry for add and the borrow
    // (unsigned a < b) for subtract.
    assign w_ext   = i_sub ? ({1'b0, i_a} - {1'b0, i_b})
                           : ({1'b0, i_a} + {1'b0, i_b});
    assign o_sum   = w_ext[N-1:0];
    assign o_carry = w_ext[N];

    assign o_ovf = i_sub ? ((i_a[N-1] != i_b[N-1]) && (w_ext[N-1] != i_a[N-1]))
                         : ((i_a[N-1] == i_b[N-1]) && (w_ext[N-1] != i_a[N-1]));

endmodule : alu_addsub

`default_nettype wire

// File: rtl/alu_unit.sv
// ============================================================================
// Module      : alu_unit
// Description : N-bit ALU with registered result and {V,N,Z,C} flags.
//               Define ALU_LOGIC_OPS_EN to build the AND/OR/XOR/NOT codes;
//               otherwise codes 100-111 behave as RA.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_unit
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   func,
    output logic [3:0]   flags,
    output logic [N-1:0] result
);

    logic [N-1:0] w_sum;
    logic         w_carry;
    logic         w_ovf;
    logic         w_sub;
    logic [N-1:0] w_res;
    logic         w_v;
    logic         w_c;
    logic [3:0]   w_flags;

    logic [N-1:0] r_result;
    logic [3:0]   r_flags;

    assign w_sub = (func == RSUB);

    alu_addsub #(
        .N (N)
    ) u_addsub (
        .i_a     (a),
        .i_b     (b),
        .i_sub   (w_sub),
        .o_sum   (w_sum),
        .o_carry (w_carry),
        .o_ovf   (w_ovf)
    );

    always_comb begin
        w_res = a;
        w_v   = 1'b0;
        w_c   = 1'b0;
        case (func)
            RA:   w_res = a;
            RB:   w_res = b;
            RADD, RSUB: begin
                w_res = w_sum;
                w_v   = w_ovf;
                w_c   = w_carry;
            end
`ifdef ALU_LOGIC_OPS_EN
            RAND: w_res = a & b;
            ROR:  w_res = a | b;
            RXOR: w_res = a ^ b;
            RNOT: w_res = ~a;
`endif
            // Without the logic ops, the upper codes fall back to passing a.
            default: w_res = a;
        endcase
    end

    always_comb begin
        w_flags         = 4'b0000;
        w_flags[FLAG_V] = w_v;
        w_flags[FLAG_N] = w_res[N-1];
        w_flags[FLAG_Z] = (w_res == '0);
        w_flags[FLAG_C] = w_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_flags  <= 4'b0000;
        end else begin
            r_result <= w_res;
            r_flags  <= w_flags;
        end
    end

    assign result = r_result;
    assign flags  = r_flags;

endmodule : alu_unit

`default_nettype wire

// File: tb/tb_alu_unit.sv
// ============================================================================
// Module      : tb_alu_unit
// Description : Scoreboard bench for alu_unit: directed vectors plus random
//               traffic checked against an integer reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_unit;
    import alu_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   fl;
        string        tag;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   func;
    logic [3:0]   flags;
    logic [W-1:0] result;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_unit #(
        .N (W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .a      (a),
        .b      (b),
        .func   (func),
        .flags  (flags),
        .result (result)
    );

    // Reference model in plain integer arithmetic on unsigned/signed values.
    function automatic exp_t model(input int ua, input int ub, input int f);
        exp_t e;
        int   mask = (1 << W) - 1;
        int   half = 1 << (W - 1);
        int   sa   = (ua >= half) ? ua - (1 << W) : ua;
        int   sb   = (ub >= half) ? ub - (1 << W) : ub;
        int   raw  = ua;
        int   res;
        bit   v = 0, c = 0;
        case (f)
            0: raw = ua;
            1: raw = ub;
            2: begin
                raw = ua + ub;
                c   = (raw > mask);
                v   = (sa + sb > half - 1) || (sa + sb < -half);
            end
            3: begin
                raw = ua - ub;
                c   = (ua < ub);
                v   = (sa - sb > half - 1) || (sa - sb < -half);
            end
`ifdef ALU_LOGIC_OPS_EN
            4: raw = ua & ub;
            5: raw = ua | ub;
            6: raw = ua ^ ub;
            7: raw = ~ua;
`endif
            default: raw = ua;
        endcase
        res   = raw & mask;
        e.res = res[W-1:0];
        e.fl  = {v, (res >= half), (res == 0), c};
        e.tag = "model";
        return e;
    endfunction

    task automatic drive(input logic r, input logic [2:0] f,
                         input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] er, input logic [3:0] ef,
                         input string tag);
        exp_t e;
        @(negedge clk);
        reset = r;
        func  = f;
        a     = x;
        b     = y;
        e.res = er;
        e.fl  = ef;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic drive_model(input logic [2:0] f, input logic [W-1:0] x,
                               input logic [W-1:0] y, input string tag);
        exp_t e;
        e = model(int'(x), int'(y), int'(f));
        drive(1'b0, f, x, y, e.res, e.fl, tag);
    endtask

    // Monitor: each edge registers the inputs pushed at the previous negedge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if (result !== e.res || flags !== e.fl) begin
                errors++;
                $display("FAIL %s: got result=%0d flags=%b, expected result=%0d flags=%b",
                         e.tag, result, flags, e.res, e.fl);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]   f;
        logic [W-1:0] x, y;
        reset = 1'b1;
        a     = '0;
        b     = '0;
        func  = RA;

        drive(1'b1, RADD, 8'd5, 8'd7, 8'd0, 4'b0000, "reset_1");
        drive(1'b1, RADD, 8'd5, 8'd7, 8'd0, 4'b0000, "reset_2");
        drive(1'b0, RADD, 8'd5, 8'd7, 8'd12, 4'b0000, "reset_release");

        drive(1'b0, RADD, 8'd1,   8'd1,   8'd2,   4'b0000, "add_1_1");
        drive(1'b0, RADD, 8'd0,   8'd0,   8'd0,   4'b0010, "add_0_0");
        drive(1'b0, RADD, 8'd255, 8'd1,   8'd0,   4'b0011, "add_255_1");
        drive(1'b0, RADD, 8'd5,   8'hF6,  8'd251, 4'b0100, "add_5_m10");
        drive(1'b0, RADD, 8'd127, 8'd127, 8'd254, 4'b1100, "add_127_127");

        drive(1'b0, RSUB, 8'd2,   8'd1, 8'd1,   4'b0000, "sub_2_1");
        drive(1'b0, RSUB, 8'd1,   8'd2, 8'd255, 4'b0101, "sub_1_2");
        drive(1'b0, RSUB, 8'd128, 8'd1, 8'd127, 4'b1000, "sub_128_1");
        drive(1'b0, RSUB, 8'd7,   8'd7, 8'd0,   4'b0010, "sub_7_7");

        drive(1'b0, RA, 8'hE8, 8'd45, 8'd232, 4'b0100, "ra_m24_45");
        drive(1'b0, RB, 8'hE8, 8'd45, 8'd45,  4'b0000, "rb_m24_45");
        drive(1'b0, RB, 8'd0,  8'd0,  8'd0,   4'b0010, "rb_0_0");

`ifdef ALU_LOGIC_OPS_EN
        drive(1'b0, RAND, 8'hF0, 8'h3C, 8'h30, 4'b0000, "and_f0_3c");
        drive(1'b0, RXOR, 8'hAA, 8'hAA, 8'h00, 4'b0010, "xor_aa_aa");
        drive(1'b0, RNOT, 8'h0F, 8'($urandom), 8'hF0, 4'b0100, "not_0f");
        drive(1'b0, ROR,  8'h12, 8'h81, 8'h93, 4'b0100, "or_12_81");
`else
        drive(1'b0, RAND, 8'hF0, 8'h3C, 8'hF0, 4'b0100, "and_as_ra");
        drive(1'b0, RXOR, 8'h00, 8'hAA, 8'h00, 4'b0010, "xor_as_ra");
        drive(1'b0, RNOT, 8'h0F, 8'hFF, 8'h0F, 4'b0000, "not_as_ra");
`endif

        // Back-to-back: every func code in consecutive cycles, no bubbles.
        for (int i = 0; i < 8; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            drive_model(3'(i), x, y, "pipe");
        end

        // Random traffic with occasional mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            f = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       x = 8'($urandom_range(0, 1) ? 8'h80 : 8'h7F);
                default: x = 8'($urandom);
            endcase
            y = 8'($urandom);
            if ($urandom_range(0, 19) == 0)
                drive(1'b1, f, x, y, 8'd0, 4'b0000, "rand_reset");
            else
                drive_model(f, x, y, "random");
        end

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses never observed, required 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_alu_unit

`default_nettype wire

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- Parameterised n-bit integer ALU with registered result and condition flags {V,N,Z,C}.
- Executes one of eight 3-bit function codes on operands a and b every clock.
- Sits in the processor datapath between the register file and the writeback/branch logic.
- The flags feed conditional-branch evaluation.

Parameters:
n, 8, datapath width in bits for a, b and result (minimum 2).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
a  input  n  operand A.
b  input  n  operand B.
func  input  3  function code (see Behaviour).
flags  output  4  registered condition flags {V,N,Z,C}: bit3=V, bit2=N, bit1=Z, bit0=C.
result  output  n  registered operation result.

Behaviour:
- One clock, single-edge design. Reset is synchronous and active-high; there is no asynchronous reset path.
- When reset=1 at a rising edge: result <= 0 and flags <= 4'b0000. Reset wins over any operation in that cycle.
- Latency is one cycle. Inputs sampled at edge k appear on result/flags after edge k. There is no handshake, and a new operation is accepted every cycle.
- Function codes:
  - RA=000: result=a.
  - RB=001: result=b.
  - RADD=010: result=a+b.
  - RSUB=011: result=a-b.
  - RAND=100: result=a&b.
  - ROR=101: result=a|b.
  - RXOR=110: result=a^b.
  - RNOT=111: result=~a.
- Arithmetic is computed in n+1 bits and result takes the low n bits (wrap-around).
- N = result[n-1], for all codes.
- Z = (result == 0), for all codes.
- RADD flags:
  - C = carry-out bit n of the (n+1)-bit sum.
  - V = (a[n-1]==b[n-1]) && (result[n-1]!=a[n-1]).
- RSUB flags:
  - C = borrow, i.e. 1 when unsigned a < unsigned b (bit n of the zero-extended a-b).
  - V = (a[n-1]!=b[n-1]) && (result[n-1]!=a[n-1]).
- Non-arithmetic codes (RA, RB, logic ops): V=0, C=0.
- Operands are treated as raw bit vectors. Signedness matters only for the V and N interpretation.
- No X propagation requirement. The datapath logic is purely combinational before the output registers.

Optional Feature:
- Macro ALU_LOGIC_OPS_EN.
- Defined: codes 100-111 perform AND/OR/XOR/NOT as specified above.
- Undefined: codes 100-111 behave exactly as RA (result=a, V=0, C=0, N/Z from result). The logic-op hardware is not synthesised.
- RA, RB, RADD and RSUB are unaffected by the macro either way.

Decomposition:
- Shared package alu_pkg holds:
  - the 3-bit func code constants/enum (RA, RB, RADD, RSUB, RAND, ROR, RXOR, RNOT);
  - the flag bit index constants (FLAG_V=3, FLAG_N=2, FLAG_Z=1, FLAG_C=0).
- One combinational sub-module, alu_addsub, is natural.
  - Inputs: a, b, sub select.
  - Outputs: n-bit sum, carry/borrow, overflow.
  - The top level muxes results, derives N/Z, and registers the outputs.

Test Plan:
- Reset: assert reset for 2 cycles with a=5, b=7, func=RADD -> result=0, flags=0000 after each edge. Deassert -> result=12, flags=0000 one cycle later.
- RADD: (1,1) -> 2, 0000; (0,0) -> 0, 0010; (255,1) -> 0, 0011; (5,-10) -> 251, 0100; (127,127) -> 254, 1100.
- RSUB: (2,1) -> 1, 0000; (1,2) -> 255, 0101; (128,1) -> 127, 1000; (7,7) -> 0, 0010.
- RA/RB: RA (-24,45) -> 232, 0100; RB (-24,45) -> 45, 0000; RB (0,0) -> 0, 0010.
- Logic ops with ALU_LOGIC_OPS_EN: RAND (F0,3C) -> 30, 0000; RXOR (AA,AA) -> 00, 0010; RNOT (0F,x) -> F0, 0100. Without the macro, RAND (F0,3C) -> F0, 0100.
- Pipelining: change func/operands every cycle for 8 consecutive cycles -> each result/flags pair matches its inputs exactly one edge later, with no bubbles.
